// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core constants for the fetch stage and decode opcodes
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
endpackage

// File: rtl/pipe_reg_en.sv
// pipe_reg_en: W-bit register with sync reset, flush value and enable (rst > flush > en)
module pipe_reg_en #(
  parameter int W = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] FLUSH_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? RST_VAL : flush ? FLUSH_VAL : en ? d : q;
endmodule

// File: rtl/fetch_if_id_stage.sv
// fetch_if_id_stage: PC, next-PC select, IF/ID register and stall/flush event counters
module fetch_if_id_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic             if_id_write,
  input  logic             if_flush,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump_taken,
  input  logic [31:0]      jump_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      pc_IF_ID,
  output logic [31:0]      instruction_IF_ID,
  output logic             valid_IF_ID,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  logic [31:0] next_pc;
  assign next_pc = jump_taken ? {jump_target[31:2], 2'b00} :
                   branch_taken ? {branch_target[31:2], 2'b00} : imem_addr + 32'd4;
  pipe_reg_en #(.W(32), .RST_VAL(RESET_PC), .FLUSH_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .en(pc_write), .flush(1'b0), .d(next_pc), .q(imem_addr)
  );
  pipe_reg_en #(.W(32), .RST_VAL(32'd0), .FLUSH_VAL(32'd0)) u_pc_if_id (
    .clk(clk), .rst(rst), .en(if_id_write), .flush(if_flush), .d(imem_addr), .q(pc_IF_ID)
  );
  pipe_reg_en #(.W(32), .RST_VAL(NOP_INSTR), .FLUSH_VAL(NOP_INSTR)) u_instr_if_id (
    .clk(clk), .rst(rst), .en(if_id_write), .flush(if_flush), .d(imem_rdata), .q(instruction_IF_ID)
  );
  pipe_reg_en #(.W(1), .RST_VAL(1'b0), .FLUSH_VAL(1'b0)) u_valid_if_id (
    .clk(clk), .rst(rst), .en(if_id_write), .flush(if_flush), .d(1'b1), .q(valid_IF_ID)
  );
  always_ff @(posedge clk)
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!if_flush && !if_id_write && !(&stall_count)) stall_count <= stall_count + 1'b1;
      if (if_flush && !(&flush_count)) flush_count <= flush_count + 1'b1;
    end
endmodule

// File: tb/tb_fetch_if_id_stage.sv
// tb_fetch_if_id_stage: directed + random stimulus against a cycle-level reference model
module tb_fetch_if_id_stage;
  localparam int CW = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst, pc_write, if_id_write, if_flush, branch_taken, jump_taken;
  logic [31:0] branch_target, jump_target, imem_addr, imem_rdata, pc_IF_ID, instruction_IF_ID;
  logic valid_IF_ID;
  logic [CW-1:0] stall_count, flush_count;
  int total = 0, bad = 0;
  logic [31:0] m_pc, m_ipc, m_instr;
  logic m_valid;
  int m_stall, m_flush;
  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ KEY;
  fetch_if_id_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_write(if_id_write), .if_flush(if_flush),
    .branch_taken(branch_taken), .branch_target(branch_target), .jump_taken(jump_taken),
    .jump_target(jump_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_IF_ID(pc_IF_ID), .instruction_IF_ID(instruction_IF_ID), .valid_IF_ID(valid_IF_ID),
    .stall_count(stall_count), .flush_count(flush_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic pw, input logic iw, input logic fl,
                      input logic br, input logic [31:0] bt, input logic jp, input logic [31:0] jt);
    logic [31:0] word;
    if ((br || jp) && !pw) begin
      bad++;
      $display("FAIL redirect_without_pc_write t=%0t", $time);
    end
    rst = r; pc_write = pw; if_id_write = iw; if_flush = fl;
    branch_taken = br; branch_target = bt; jump_taken = jp; jump_target = jt;
    word = m_pc ^ KEY;
    @(posedge clk); #1;
    if (r) begin
      m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (fl) begin
        m_ipc = 0; m_instr = NOP; m_valid = 0;
        m_flush = (m_flush < SAT) ? m_flush + 1 : SAT;
      end else if (iw) begin
        m_ipc = m_pc; m_instr = word; m_valid = 1;
      end else m_stall = (m_stall < SAT) ? m_stall + 1 : SAT;
      if (pw) m_pc = jp ? (jt / 4) * 4 : br ? (bt / 4) * 4 : m_pc + 32'd4;
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_IF_ID", pc_IF_ID, m_ipc);
    chk("instr_IF_ID", instruction_IF_ID, m_instr);
    chk("valid_IF_ID", {31'd0, valid_IF_ID}, {31'd0, m_valid});
    chk("stall_count", {28'd0, stall_count}, m_stall);
    chk("flush_count", {28'd0, flush_count}, m_flush);
  endtask
  task automatic fetch();
    step(0, 1, 1, 0, 0, 0, 0, 0);
  endtask
  initial begin
    m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_stall = 0; m_flush = 0;
    step(1, 1, 1, 0, 0, 0, 0, 0);
    chk("reset_pc", imem_addr, 32'h0);
    chk("reset_instr", instruction_IF_ID, NOP);
    fetch();
    chk("first_fetch_pc", pc_IF_ID, 32'h0);
    chk("first_fetch_instr", instruction_IF_ID, 32'hA5A5_0000);
    fetch();
    chk("second_fetch_instr", instruction_IF_ID, 32'hA5A5_0004);
    chk("third_addr", imem_addr, 32'h8);
    fetch(); fetch();
    chk("at_0x10", imem_addr, 32'h10);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_hold_addr", imem_addr, 32'h10);
    chk("stall_count_3", {28'd0, stall_count}, 32'd3);
    fetch();
    chk("resume_ipc", pc_IF_ID, 32'h10);
    step(0, 1, 1, 1, 1, 32'h103, 0, 0);
    chk("branch_addr", imem_addr, 32'h100);
    chk("flush_valid", {31'd0, valid_IF_ID}, 32'd0);
    chk("flush_count_1", {28'd0, flush_count}, 32'd1);
    step(0, 1, 1, 0, 1, 32'h200, 1, 32'h300);
    chk("jump_wins", imem_addr, 32'h300);
    step(0, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFF);
    chk("preset_top", imem_addr, 32'hFFFF_FFFC);
    fetch();
    chk("wrap", imem_addr, 32'h0);
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_sat", {28'd0, stall_count}, SAT);
    repeat (18) step(0, 1, 0, 1, 0, 0, 0, 0);
    chk("flush_sat", {28'd0, flush_count}, SAT);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_rst_cnt", {28'd0, stall_count}, 32'd0);
    chk("mid_rst_pc", imem_addr, 32'h0);
    step(1, 1, 1, 1, 1, 32'h40, 1, 32'h80);
    chk("rst_over_redirect", imem_addr, 32'h0);
    for (int i = 0; i < 400; i++) begin
      logic pw, br, jp;
      pw = ($urandom_range(0, 3) != 0);
      br = pw && ($urandom_range(0, 5) == 0);
      jp = pw && ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 49) == 0, pw, $urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
           br, $urandom, jp, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
